// File: rtl/lstm_gate_dispatch.sv
// Sequencer that steers a 4*VEC_LEN word frame into the four LSTM gate lanes.
// Define GATE_INTERLEAVE_EN for element-major (gate-interleaved) word ordering.
module lstm_gate_dispatch #(
  parameter int DATA_WIDTH = 32,
  parameter int VEC_LEN = 8,
  localparam int EW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            data_sel,
  output logic                  demux_en,
  input  logic [3:0]            gate_ready,
  output logic [EW-1:0]         elem_idx,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [EW-1:0] ELEM_MAX = EW'(VEC_LEN - 1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_sel;
  logic [1:0]            r_gate;
  logic [EW-1:0]         r_idx;
  logic [EW-1:0]         r_elem;
  logic                  r_en;

  logic w_xfer;
  logic w_acc;
  logic w_rdy;
  logic w_elem_wrap;
  logic w_gate_wrap;
  logic w_last;

  assign w_xfer      = r_en && gate_ready[r_sel];
  assign w_rdy       = (r_state == S_RUN) && (!r_en || gate_ready[r_sel]);
  assign w_acc       = in_valid && w_rdy;
  assign w_elem_wrap = (r_elem == ELEM_MAX);
  assign w_gate_wrap = (r_gate == 2'd3);
  // Both orderings end on gate 3, last element.
  assign w_last      = w_elem_wrap && w_gate_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_sel   <= '0;
      r_idx   <= '0;
      r_en    <= 1'b0;
      r_gate  <= '0;
      r_elem  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_gate  <= '0;
            r_elem  <= '0;
          end
        end
        S_RUN: begin
          if (w_acc) begin
            r_data <= in_data;
            r_sel  <= r_gate;
            r_idx  <= r_elem;
            r_en   <= 1'b1;
`ifdef GATE_INTERLEAVE_EN
            r_gate <= r_gate + 2'd1;
            if (w_gate_wrap)
              r_elem <= w_elem_wrap ? '0 : r_elem + EW'(1);
`else
            r_elem <= w_elem_wrap ? '0 : r_elem + EW'(1);
            if (w_elem_wrap)
              r_gate <= r_gate + 2'd1;
`endif
            if (w_last)
              r_state <= S_DRAIN;
          end else if (w_xfer) begin
            r_en <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (w_xfer) begin
            r_en    <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = w_rdy;
  assign data_out = r_data;
  assign data_sel = r_sel;
  assign elem_idx = r_idx;
  assign demux_en = r_en;
  assign busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done     = (r_state == S_DONE);

endmodule
